// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for sram_set_array.
package sram_pkg;
  typedef enum logic {INIT, RUN} sram_init_state_e;
  localparam int MAX_WAY = 32;
  localparam int MAX_BITS = 2048;
  function automatic logic [MAX_BITS-1:0] waymask_expand(
    input logic [MAX_WAY-1:0] mask,
    input int gen_width,
    input int num_way
  );
    logic [MAX_BITS-1:0] way_ones;
    waymask_expand = '0;
    way_ones = ~({MAX_BITS{1'b1}} << gen_width);
    for (int w = 0; w < MAX_WAY; w++)
      if (w < num_way && mask[w]) waymask_expand |= way_ones << (w * gen_width);
  endfunction
endpackage

// File: rtl/dualportSRAM.sv
// dualportSRAM: one read port, one bit-masked write port, registered read-first output.
module dualportSRAM #(
  parameter int BITWIDTH = 64,
  parameter int DEPTH = 5
) (
  input  logic                clk,
  input  logic                ren,
  input  logic [DEPTH-1:0]    raddr,
  output logic [BITWIDTH-1:0] rdata,
  input  logic                wen,
  input  logic [DEPTH-1:0]    waddr,
  input  logic [BITWIDTH-1:0] wdata,
  input  logic [BITWIDTH-1:0] wmask
);
  logic [BITWIDTH-1:0] mem [2**DEPTH];
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    if (ren) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sram_set_array.sv
// sram_set_array: set/way SRAM wrapper with init walker and handshaked read/write ports.
// Define SRAM_WR_FWD_EN to forward a full-mask same-set write to a colliding read instead of stalling it.
module sram_set_array
  import sram_pkg::*;
#(
  parameter int GEN_WIDTH = 32,
  parameter int NUM_SET = 32,
  parameter int NUM_WAY = 2,
  parameter int SET_DEPTH = $clog2(NUM_SET),
  parameter logic [GEN_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         init_done_o,
  input  logic                         r_req_valid_i,
  output logic                         r_req_ready_o,
  input  logic [SET_DEPTH-1:0]         r_req_setid_i,
  output logic                         r_resp_valid_o,
  input  logic                         r_resp_ready_i,
  output logic [NUM_WAY*GEN_WIDTH-1:0] r_resp_data_o,
  input  logic                         w_req_valid_i,
  output logic                         w_req_ready_o,
  input  logic [SET_DEPTH-1:0]         w_req_setid_i,
  input  logic [NUM_WAY-1:0]           w_req_waymask_i,
  input  logic [NUM_WAY*GEN_WIDTH-1:0] w_req_data_i
);
  localparam int BITS = NUM_WAY * GEN_WIDTH;
  sram_init_state_e state_q, state_d;
  logic [SET_DEPTH-1:0] cnt_q, cnt_d, sram_waddr;
  logic resp_valid_q, resp_valid_d, fresh_q, fresh_d, oor_q, oor_d;
  logic [BITS-1:0] hold_q, hold_d, sram_rdata, live_data, sram_wdata, sram_wmask;
  logic run, w_fire, collision, fwd, r_fire, r_oor, sram_ren, sram_wen;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      fresh_q      <= 1'b0;
      oor_q        <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      fresh_q      <= fresh_d;
      oor_q        <= oor_d;
      hold_q       <= hold_d;
    end
  end
  always_comb begin
    state_d = (state_q == INIT && cnt_q == SET_DEPTH'(NUM_SET - 1)) ? RUN : state_q;
    cnt_d   = (state_q == INIT) ? cnt_q + SET_DEPTH'(1) : cnt_q;
  end
  always_comb begin
    run           = state_q == RUN;
    init_done_o   = run;
    w_req_ready_o = run;
  end
  assign w_fire    = run && w_req_valid_i;
  assign collision = w_fire && r_req_valid_i && (r_req_setid_i == w_req_setid_i);
`ifdef SRAM_WR_FWD_EN
  logic fwd_q, fwd_d;
  logic [BITS-1:0] fwd_data_q, fwd_data_d;
  assign fwd = collision && (&w_req_waymask_i);
  always_comb begin
    fwd_d      = r_fire && fwd;
    fwd_data_d = (r_fire && fwd) ? w_req_data_i : fwd_data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end
  assign live_data = oor_q ? '0 : fwd_q ? fwd_data_q : sram_rdata;
`else
  assign fwd       = 1'b0;
  assign live_data = oor_q ? '0 : sram_rdata;
`endif
  always_comb begin
    r_req_ready_o  = run && (!collision || fwd) && (!resp_valid_q || r_resp_ready_i);
    r_fire         = r_req_valid_i && r_req_ready_o;
    r_oor          = int'(r_req_setid_i) >= NUM_SET;
    sram_ren       = r_fire && !r_oor && !fwd;
    sram_wen       = !run || (w_fire && int'(w_req_setid_i) < NUM_SET);
    sram_waddr     = run ? w_req_setid_i : cnt_q;
    sram_wdata     = run ? w_req_data_i : {NUM_WAY{INIT_VALUE}};
    sram_wmask     = run ? BITS'(waymask_expand(MAX_WAY'(w_req_waymask_i), GEN_WIDTH, NUM_WAY)) : '1;
    resp_valid_d   = r_fire || (resp_valid_q && !r_resp_ready_i);
    fresh_d        = r_fire;
    oor_d          = r_oor;
    // The SRAM output is only trusted on the cycle right after the read; park it if not taken.
    hold_d         = (fresh_q && !r_resp_ready_i) ? live_data : hold_q;
    r_resp_valid_o = resp_valid_q;
    r_resp_data_o  = fresh_q ? live_data : hold_q;
  end
  dualportSRAM #(
    .BITWIDTH(BITS),
    .DEPTH   (SET_DEPTH)
  ) u_sram (
    .clk  (clk),
    .ren  (sram_ren),
    .raddr(r_req_setid_i),
    .rdata(sram_rdata),
    .wen  (sram_wen),
    .waddr(sram_waddr),
    .wdata(sram_wdata),
    .wmask(sram_wmask)
  );
endmodule

// File: doc/sram_set_array.md
# sram_set_array

Parametrised set/way SRAM wrapper for the SP instruction cache tag and data arrays. It puts valid/ready handshakes on the read request, write request and read response ports. After reset it walks every set to a known value before serving traffic, and it resolves same-set read/write collisions by stalling the read or, optionally, by forwarding the write. It instantiates the shared `dualportSRAM` macro and sits between the I-cache controller and the storage.

## Interface
- `GEN_WIDTH`, 32: bits per way.
- `NUM_SET`, 32: number of sets; need not be a power of two.
- `NUM_WAY`, 2: number of ways, ≥1.
- `SET_DEPTH`, `$clog2(NUM_SET)`: set-index width.
- `INIT_VALUE`, `'0`: per-way value written to every set during initialisation.
- `clk` in 1: clock; one clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `init_done_o` out 1: high once initialisation is complete.
- `r_req_valid_i` in 1; `r_req_ready_o` out 1; `r_req_setid_i` in `SET_DEPTH`: read request.
- `r_resp_valid_o` out 1; `r_resp_ready_i` in 1; `r_resp_data_o` out `NUM_WAY*GEN_WIDTH`: read response, way k in `[k*GEN_WIDTH +: GEN_WIDTH]`.
- `w_req_valid_i` in 1; `w_req_ready_o` out 1; `w_req_setid_i` in `SET_DEPTH`; `w_req_waymask_i` in `NUM_WAY`; `w_req_data_i` in `NUM_WAY*GEN_WIDTH`: write request; masked ways are written.

## Operation
- **FSM `INIT`→`RUN`.**
  - `INIT`: a counter walks sets 0..`NUM_SET-1`, one per cycle. Each step writes `INIT_VALUE` to all ways (full mask).
  - While in `INIT`: `init_done_o`=0, `r_req_ready_o`=0, `w_req_ready_o`=0.
  - After the write to set `NUM_SET-1` the FSM enters `RUN` and stays there until reset.
- **Write.** `w_req_ready_o`=1 in `RUN`. A write is accepted when valid and ready, and it updates the SRAM in the same cycle with the bit mask expanded from `w_req_waymask_i`. A setid ≥ `NUM_SET` is accepted but dropped.
- **Read accept.** `r_req_ready_o` = `RUN` && !collision && (!`r_resp_valid_o` || `r_resp_ready_i`). This is combinational on `r_resp_ready_i`.
- **Collision.** An accepted write and a valid read to the same setid in the same cycle. Writes always have priority, and the read is held off (ready=0) for that cycle. A retried read returns post-write data.
- **Response.** Data is valid the cycle after accept.
  - If `r_resp_ready_i` is low, the data is captured into a hold register.
  - `r_resp_valid_o` and the data stay stable until a cycle with `r_resp_ready_i`=1.
- **Out-of-range read.** A read with setid ≥ `NUM_SET` is accepted; its response is all zeros.
- **Write after read.** A write to the same set in the response cycle does not alter the response: the read observes state before the write.

## Timing
- **Reset.** `rst_n` low at any edge forces, at that edge: state `INIT`, counter 0, `r_resp_valid_o`=0, hold register 0, forward flag 0. An in-flight response is discarded. All outputs reset to 0.
- **Initialisation time.** `init_done_o` rises `NUM_SET` cycles after the first edge with `rst_n` high.
- **Read latency.** 1 cycle, request accept to `r_resp_valid_o`.
- **Throughput.** One read per cycle under continuous `r_resp_ready_i`=1 with no collisions.
- **Write latency.** Write at edge T is visible to a read accepted at T+1 or later.

## Configuration
- **`SRAM_WR_FWD_EN` defined.**
  - A collision where `w_req_waymask_i` is all ones does not stall: the read is accepted and the SRAM read enable is suppressed.
  - The response returns the write data, registered. The same response rules apply.
  - A partial-mask collision still stalls.
- **`SRAM_WR_FWD_EN` undefined.** Every collision stalls, and the forward flag and data register are not built.

## Structure
- **Package `sram_pkg`.**
  - `typedef enum logic {INIT, RUN} sram_init_state_e`.
  - Function `waymask_expand` (NUM_WAY→bit mask).
- **Storage.** The only sub-module is the existing `dualportSRAM` (BITWIDTH=`NUM_WAY*GEN_WIDTH`, DEPTH=`SET_DEPTH`).
  - Its write port is muxed between the init walker and the user write.
  - Control logic stays in this module.

## Test plan
- **Initialisation.** Reset with NUM_SET=32, INIT_VALUE=0 → `init_done_o` rises on cycle 32. Reads of sets 0..31 return 0, and ready stays 0 before then.
- **Partial write, read back.** Write set 5, mask 2'b10, data {32'hA5A5A5A5, 32'h1}; then read set 5 → response {32'hA5A5A5A5, 32'h0} one cycle after accept.
- **Stalled collision.** Same-cycle write set 7 (mask 2'b01, way0=32'hBEEF) and read set 7 → read ready=0 that cycle. Read accepted next cycle, returns way0=32'hBEEF.
- **Forwarded collision.** With `SRAM_WR_FWD_EN`, same-cycle full-mask write set 3 = {32'h2, 32'h3} and read set 3 → read accepted with no stall. Response {32'h2, 32'h3}.
- **Response backpressure.** Read set 9, hold `r_resp_ready_i`=0 for 4 cycles while writing set 9 → data stable at the pre-write value, `r_req_ready_o`=0. Released on the cycle ready=1.
- **Reset mid-operation.** Assert `rst_n`=0 with `r_resp_valid_o`=1 → next edge: valid=0, `init_done_o`=0. Re-initialisation completes in NUM_SET cycles and set 5 reads back 0.
